// File: rtl/custom_pkg.sv
// Pipeline-private types: control bundle, ALU operation, result mux encoding, hazard controls.
package custom_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_t;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic [1:0] result_src;
        alu_op_t    alu_op;
        logic [2:0] funct3;
    } ctrl_t;

    typedef struct packed {
        logic stall_ex;
        logic flush_ex;
    } hazard_t;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_sel_t;

    // alt selects SUB/SRA; the caller decides whether funct7[5] is meaningful.
    function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/riscv_pkg.sv
// RV32I base ISA encodings: opcodes, funct3/funct7 values and the two SYSTEM words.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_BR_RSV0 = 3'b010;
    localparam logic [2:0] F3_BR_RSV1 = 3'b011;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_FENCE   = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational reads and one write; x0 hardwired to zero.
module regfile #(
    parameter bit RfBypass = 1'b1
) (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] r_mem [0:31];
    logic        w_wr_en;

    assign w_wr_en = we_i && (waddr_i != 5'd0);

    // Storage deliberately has no reset; entry 0 is never written.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata1_o = r_mem[raddr1_i];
        if (raddr1_i == 5'd0) begin
            rdata1_o = 32'd0;
        end else if (RfBypass && w_wr_en && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
        end
    end

    always_comb begin
        rdata2_o = r_mem[raddr2_i];
        if (raddr2_i == 5'd0) begin
            rdata2_o = 32'd0;
        end else if (RfBypass && w_wr_en && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
        end
    end

endmodule

// File: rtl/decode.sv
// RV32I decode stage: control decode, immediate generation, RF read, ID/EX register.
module decode
    import custom_pkg::*;
    import riscv_pkg::*;
#(
    parameter bit RfBypass = 1'b1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_i,
    input  hazard_t     hazard_i,
    input  logic        rf_we_i,
    input  logic [4:0]  rf_waddr_i,
    input  logic [31:0] rf_wdata_i,
    output logic [4:0]  rs1_id_o,
    output logic [4:0]  rs2_id_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    output ctrl_t       ctrl_o,
    output logic        illegal_o
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    ctrl_t       w_ctrl;
    logic        w_illegal;
    imm_sel_t    w_imm_sel;
    logic        w_use_rs1;
    logic        w_use_rs2;
    logic        w_use_rd;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [4:0]  w_rd_idx;
    logic [31:0] w_imm;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    ctrl_t       r_ctrl;
    logic        r_illegal;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];

    // Only legal branches set control/use flags, so illegal words fall out all-zero.
    always_comb begin
        w_ctrl    = '0;
        w_illegal = 1'b0;
        w_imm_sel = IMM_NONE;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        if (instr_i != 32'd0) begin
            case (w_opcode)
                OPC_OP: begin
                    if (w_funct7 == F7_BASE ||
                        (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA))) begin
                        w_ctrl.reg_write = 1'b1;
                        w_ctrl.alu_op    = alu_op_from_f3(w_funct3, w_funct7[5]);
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                        w_use_rd  = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_OP_IMM: begin
                    if ((w_funct3 != F3_SLL && w_funct3 != F3_SRL_SRA) ||
                        (w_funct3 == F3_SLL && w_funct7 == F7_BASE) ||
                        (w_funct3 == F3_SRL_SRA && (w_funct7 == F7_BASE || w_funct7 == F7_ALT))) begin
                        w_ctrl.reg_write   = 1'b1;
                        w_ctrl.alu_src_imm = 1'b1;
                        w_ctrl.alu_op      = alu_op_from_f3(w_funct3,
                                                 (w_funct3 == F3_SRL_SRA) && w_funct7[5]);
                        w_imm_sel = IMM_I;
                        w_use_rs1 = 1'b1;
                        w_use_rd  = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_LOAD: begin
                    if (w_funct3 == F3_LB || w_funct3 == F3_LH || w_funct3 == F3_LW ||
                        w_funct3 == F3_LBU || w_funct3 == F3_LHU) begin
                        w_ctrl.reg_write   = 1'b1;
                        w_ctrl.mem_read    = 1'b1;
                        w_ctrl.alu_src_imm = 1'b1;
                        w_ctrl.result_src  = RES_MEM;
                        w_ctrl.alu_op      = ALU_ADD;
                        w_ctrl.funct3      = w_funct3;
                        w_imm_sel = IMM_I;
                        w_use_rs1 = 1'b1;
                        w_use_rd  = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_STORE: begin
                    if (w_funct3 == F3_SB || w_funct3 == F3_SH || w_funct3 == F3_SW) begin
                        w_ctrl.mem_write   = 1'b1;
                        w_ctrl.alu_src_imm = 1'b1;
                        w_ctrl.alu_op      = ALU_ADD;
                        w_ctrl.funct3      = w_funct3;
                        w_imm_sel = IMM_S;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_BRANCH: begin
                    if (w_funct3 != F3_BR_RSV0 && w_funct3 != F3_BR_RSV1) begin
                        w_ctrl.branch = 1'b1;
                        w_ctrl.alu_op = ALU_SUB;
                        w_ctrl.funct3 = w_funct3;
                        w_imm_sel = IMM_B;
                        w_use_rs1 = 1'b1;
                        w_use_rs2 = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_JAL: begin
                    // ALU computes the target (PC + imm); rd receives PC+4.
                    w_ctrl.reg_write   = 1'b1;
                    w_ctrl.jump        = 1'b1;
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.alu_src_pc  = 1'b1;
                    w_ctrl.result_src  = RES_PC4;
                    w_ctrl.alu_op      = ALU_ADD;
                    w_imm_sel = IMM_J;
                    w_use_rd  = 1'b1;
                end
                OPC_JALR: begin
                    if (w_funct3 == F3_JALR) begin
                        w_ctrl.reg_write   = 1'b1;
                        w_ctrl.jump        = 1'b1;
                        w_ctrl.jalr        = 1'b1;
                        w_ctrl.alu_src_imm = 1'b1;
                        w_ctrl.result_src  = RES_PC4;
                        w_ctrl.alu_op      = ALU_ADD;
                        w_imm_sel = IMM_I;
                        w_use_rs1 = 1'b1;
                        w_use_rd  = 1'b1;
                    end else begin
                        w_illegal = 1'b1;
                    end
                end
                OPC_LUI: begin
                    w_ctrl.reg_write   = 1'b1;
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.alu_op      = ALU_PASS_B;
                    w_imm_sel = IMM_U;
                    w_use_rd  = 1'b1;
                end
                OPC_AUIPC: begin
                    w_ctrl.reg_write   = 1'b1;
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.alu_src_pc  = 1'b1;
                    w_ctrl.alu_op      = ALU_ADD;
                    w_imm_sel = IMM_U;
                    w_use_rd  = 1'b1;
                end
                OPC_MISC_MEM: w_illegal = (w_funct3 != F3_FENCE);
                OPC_SYSTEM:   w_illegal = (instr_i != INSTR_ECALL) && (instr_i != INSTR_EBREAK);
                default:      w_illegal = 1'b1;
            endcase
        end
        if (instr_i[11:7] == 5'd0) begin
            w_ctrl.reg_write = 1'b0;
        end
    end

    always_comb begin
        w_imm = 32'd0;
        case (w_imm_sel)
            IMM_I:   w_imm = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   w_imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   w_imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                              instr_i[11:8], 1'b0};
            IMM_U:   w_imm = {instr_i[31:12], 12'd0};
            IMM_J:   w_imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                              instr_i[30:21], 1'b0};
            default: w_imm = 32'd0;
        endcase
    end

    // Unused source fields read as x0 so the hazard unit sees no false dependency.
    assign w_rs1_idx = w_use_rs1 ? instr_i[19:15] : 5'd0;
    assign w_rs2_idx = w_use_rs2 ? instr_i[24:20] : 5'd0;
    assign w_rd_idx  = w_use_rd  ? instr_i[11:7]  : 5'd0;
    assign rs1_id_o  = w_rs1_idx;
    assign rs2_id_o  = w_rs2_idx;

    regfile #(
        .RfBypass (RfBypass)
    ) u_regfile (
        .clk_i    (clk_i),
        .we_i     (rf_we_i),
        .waddr_i  (rf_waddr_i),
        .wdata_i  (rf_wdata_i),
        .raddr1_i (w_rs1_idx),
        .raddr2_i (w_rs2_idx),
        .rdata1_o (w_rs1_data),
        .rdata2_o (w_rs2_data)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i || (hazard_i.flush_ex && !hazard_i.stall_ex)) begin
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else if (!hazard_i.stall_ex) begin
            r_rs1      <= w_rs1_idx;
            r_rs2      <= w_rs2_idx;
            r_rd       <= w_rd_idx;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_imm      <= w_imm;
            r_pc       <= pc_i;
            r_pc_plus4 <= pc_plus4_i;
            r_ctrl     <= w_ctrl;
            r_illegal  <= w_illegal;
        end
    end

    assign rs1_o      = r_rs1;
    assign rs2_o      = r_rs2;
    assign rd_o       = r_rd;
    assign rs1_data_o = r_rs1_data;
    assign rs2_data_o = r_rs2_data;
    assign imm_o      = r_imm;
    assign pc_o       = r_pc;
    assign pc_plus4_o = r_pc_plus4;
    assign ctrl_o     = r_ctrl;
    assign illegal_o  = r_illegal;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: driver pushes the expected ID/EX contents, monitor pops and compares.
module tb_decode;
    import custom_pkg::*;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        ctrl_t       ctrl;
        logic        illegal;
    } out_t;

    localparam logic [7:0] F_RW  = 8'h80;
    localparam logic [7:0] F_MR  = 8'h40;
    localparam logic [7:0] F_MW  = 8'h20;
    localparam logic [7:0] F_BR  = 8'h10;
    localparam logic [7:0] F_JMP = 8'h08;
    localparam logic [7:0] F_JR  = 8'h04;
    localparam logic [7:0] F_IMM = 8'h02;
    localparam logic [7:0] F_PC  = 8'h01;

    logic        clk;
    logic        rstn;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    hazard_t     hz;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] rs1_data_q;
    logic [31:0] rs2_data_q;
    logic [31:0] imm_q;
    logic [31:0] pc_q;
    logic [31:0] pc4_q;
    ctrl_t       ctrl_q;
    logic        illegal_q;

    out_t  exp_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    decode #(.RfBypass(1'b1)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .instr_i    (instr),
        .pc_i       (pc),
        .pc_plus4_i (pc_plus4),
        .hazard_i   (hz),
        .rf_we_i    (rf_we),
        .rf_waddr_i (rf_waddr),
        .rf_wdata_i (rf_wdata),
        .rs1_id_o   (rs1_id),
        .rs2_id_o   (rs2_id),
        .rs1_o      (rs1_q),
        .rs2_o      (rs2_q),
        .rd_o       (rd_q),
        .rs1_data_o (rs1_data_q),
        .rs2_data_o (rs2_data_q),
        .imm_o      (imm_q),
        .pc_o       (pc_q),
        .pc_plus4_o (pc4_q),
        .ctrl_o     (ctrl_q),
        .illegal_o  (illegal_q)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctrl_t mk_ctrl(input logic [7:0] fl, input logic [1:0] res,
                                      input alu_op_t op, input logic [2:0] f3);
        ctrl_t c;
        c             = '0;
        c.reg_write   = fl[7];
        c.mem_read    = fl[6];
        c.mem_write   = fl[5];
        c.branch      = fl[4];
        c.jump        = fl[3];
        c.jalr        = fl[2];
        c.alu_src_imm = fl[1];
        c.alu_src_pc  = fl[0];
        c.result_src  = res;
        c.alu_op      = op;
        c.funct3      = f3;
        return c;
    endfunction

    function automatic out_t mk_out(input logic [4:0] r1, input logic [4:0] r2,
                                    input logic [4:0] rd, input logic [31:0] d1,
                                    input logic [31:0] d2, input logic [31:0] im,
                                    input logic [31:0] p, input ctrl_t c, input logic ill);
        out_t o;
        o.rs1      = r1;
        o.rs2      = r2;
        o.rd       = rd;
        o.rs1_data = d1;
        o.rs2_data = d2;
        o.imm      = im;
        o.pc       = p;
        o.pc4      = p + 32'd4;
        o.ctrl     = c;
        o.illegal  = ill;
        return o;
    endfunction

    // driver: ctl = {rstn, stall_ex, flush_ex, rf_we}
    task automatic cyc(input string n, input logic [31:0] ins, input logic [31:0] p,
                       input logic [3:0] ctl, input logic [4:0] wa, input logic [31:0] wd,
                       input out_t e);
        instr       = ins;
        pc          = p;
        pc_plus4    = p + 32'd4;
        rstn        = ctl[3];
        hz.stall_ex = ctl[2];
        hz.flush_ex = ctl[1];
        rf_we       = ctl[0];
        rf_waddr    = wa;
        rf_wdata    = wd;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk);
    endtask

    task automatic id_check(input string n, input logic [4:0] e1, input logic [4:0] e2);
        total++;
        if (rs1_id !== e1 || rs2_id !== e2) begin
            bad++;
            $display("FAIL %s: rs_id got=%0d/%0d exp=%0d/%0d", n, rs1_id, rs2_id, e1, e2);
        end
    endtask

    // scoreboard monitor
    always @(posedge clk) begin
        out_t  act;
        out_t  e;
        string n;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            act.rs1      = rs1_q;
            act.rs2      = rs2_q;
            act.rd       = rd_q;
            act.rs1_data = rs1_data_q;
            act.rs2_data = rs2_data_q;
            act.imm      = imm_q;
            act.pc       = pc_q;
            act.pc4      = pc4_q;
            act.ctrl     = ctrl_q;
            act.illegal  = illegal_q;
            total++;
            if (act !== e) begin
                bad++;
                $display("FAIL %s: got=%h exp=%h", n, act, e);
            end
        end
    end

    initial begin
        out_t z;
        out_t e_lw;
        out_t e_sw;
        ctrl_t c_rw_add;
        z        = '0;
        c_rw_add = mk_ctrl(F_RW, RES_ALU, ALU_ADD, 3'd0);
        e_lw = mk_out(5'd1, 5'd0, 5'd2, 32'h1000, 32'd0, 32'd4, 32'h200,
                      mk_ctrl(F_RW | F_MR | F_IMM, RES_MEM, ALU_ADD, 3'd2), 1'b0);
        e_sw = mk_out(5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_AAAA, 32'd8, 32'h210,
                      mk_ctrl(F_MW | F_IMM, RES_ALU, ALU_ADD, 3'd2), 1'b0);

        cyc("rst0", 32'h0050_0093, 32'h0, 4'b0000, 5'd0, 32'd0, z);
        cyc("rst1", 32'h0050_0093, 32'h4, 4'b0000, 5'd0, 32'd0, z);

        cyc("addi", 32'h0050_0093, 32'h100, 4'b1001, 5'd1, 32'h1000,
            mk_out(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, 32'h100,
                   mk_ctrl(F_RW | F_IMM, RES_ALU, ALU_ADD, 3'd0), 1'b0));
        id_check("addi_id", 5'd0, 5'd0);
        cyc("beq", 32'hFE00_0CE3, 32'h104, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h104,
                   mk_ctrl(F_BR, RES_ALU, ALU_SUB, 3'd0), 1'b0));
        cyc("add_bypass", 32'h0002_8333, 32'h108, 4'b1001, 5'd5, 32'hDEAD_BEEF,
            mk_out(5'd5, 5'd0, 5'd6, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'h108, c_rw_add, 1'b0));
        id_check("add_id", 5'd5, 5'd0);
        cyc("add_read", 32'h0012_83B3, 32'h10C, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd5, 5'd1, 5'd7, 32'hDEAD_BEEF, 32'h1000, 32'd0, 32'h10C, c_rw_add, 1'b0));
        id_check("add2_id", 5'd5, 5'd1);
        cyc("x0_write", 32'h0000_04B3, 32'h110, 4'b1001, 5'd0, 32'h1234_5678,
            mk_out(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'h110, c_rw_add, 1'b0));
        cyc("x0_read", 32'h0000_04B3, 32'h114, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'h114, c_rw_add, 1'b0));
        cyc("sub", 32'h4010_8533, 32'h118, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd1, 5'd1, 5'd10, 32'h1000, 32'h1000, 32'd0, 32'h118,
                   mk_ctrl(F_RW, RES_ALU, ALU_SUB, 3'd0), 1'b0));

        cyc("lw", 32'h0040_A103, 32'h200, 4'b1000, 5'd0, 32'd0, e_lw);
        id_check("lw_id", 5'd1, 5'd0);
        cyc("stall1", 32'hFFFF_FFFF, 32'h204, 4'b1101, 5'd1, 32'h0000_AAAA, e_lw);
        cyc("stall2", 32'h0002_8333, 32'h208, 4'b1100, 5'd0, 32'd0, e_lw);
        cyc("flush", 32'h0002_8333, 32'h20C, 4'b1010, 5'd0, 32'd0, z);
        cyc("sw", 32'h0010_2423, 32'h210, 4'b1000, 5'd0, 32'd0, e_sw);
        id_check("sw_id", 5'd0, 5'd1);
        cyc("stall_flush", 32'h0050_0093, 32'h214, 4'b1110, 5'd0, 32'd0, e_sw);

        cyc("illegal", 32'hFFFF_FFFF, 32'h300, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h300, '0, 1'b1));
        id_check("illegal_id", 5'd0, 5'd0);
        cyc("bubble", 32'h0, 32'h304, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h304, '0, 1'b0));
        cyc("jal", 32'h0100_00EF, 32'h308, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd16, 32'h308,
                   mk_ctrl(F_RW | F_JMP | F_IMM | F_PC, RES_PC4, ALU_ADD, 3'd0), 1'b0));
        cyc("lui", 32'h1234_51B7, 32'h30C, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd3, 32'd0, 32'd0, 32'h1234_5000, 32'h30C,
                   mk_ctrl(F_RW | F_IMM, RES_ALU, ALU_PASS_B, 3'd0), 1'b0));
        cyc("slli_f7", 32'h4000_1093, 32'h310, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h310, '0, 1'b1));
        cyc("ecall", 32'h0000_0073, 32'h314, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h314, '0, 1'b0));
        cyc("addi_x0", 32'h0010_0013, 32'h318, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd1, 32'h318,
                   mk_ctrl(F_IMM | F_JR & 8'h00, RES_ALU, ALU_ADD, 3'd0), 1'b0));

        cyc("rst_mid", 32'h0050_0093, 32'h400, 4'b0000, 5'd0, 32'd0, z);
        cyc("resume", 32'h0050_0093, 32'h404, 4'b1000, 5'd0, 32'd0,
            mk_out(5'd0, 5'd0, 5'd1, 32'd0, 32'd0, 32'd5, 32'h404,
                   mk_ctrl(F_RW | F_IMM, RES_ALU, ALU_ADD, 3'd0), 1'b0));

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
